// File: rtl/javk_mem_pkg.sv
// Shared types and default address-map constants for the JAVK memory/IO bus controller.
package javk_mem_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    ACCESS,
    HOLD,
    IO_WAIT,
    DONE
  } state_e;

  typedef enum logic [1:0] {
    REG_ROM,
    REG_RAM,
    REG_IO
  } region_e;

  localparam logic [15:0] ROM_TOP_DEF = 16'h4000;
  localparam logic [7:0]  IO_PAGE_DEF = 8'hFF;

endpackage

// File: rtl/javk_memctl_decode.sv
// Combinational address-to-region decode; the IO page overrides both ROM and RAM.
module javk_memctl_decode
  import javk_mem_pkg::*;
#(
  parameter logic [15:0] ROM_TOP = ROM_TOP_DEF,
  parameter logic [7:0]  IO_PAGE = IO_PAGE_DEF
) (
  input  logic [15:0] addr,
  output region_e     region
);

  always_comb begin
    region = REG_RAM;
    if (addr[15:8] == IO_PAGE) begin
      region = REG_IO;
    end else if (addr < ROM_TOP) begin
      region = REG_ROM;
    end
  end

endmodule

// File: rtl/javk_memctl.sv
// Bus controller: sequences async SRAM/ROM strobes with wait states and an IO req/ack
// handshake with timeout, returning read data and a one-cycle ready pulse to the core.
module javk_memctl
  import javk_mem_pkg::*;
#(
  parameter int unsigned WAIT_RD    = 2,
  parameter int unsigned WAIT_WR    = 2,
  parameter logic [15:0] ROM_TOP    = ROM_TOP_DEF,
  parameter logic [7:0]  IO_PAGE    = IO_PAGE_DEF,
  parameter int unsigned IO_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  output logic [7:0]  cpu_rdata,
  output logic        cpu_ready,
  output logic        busy,
  output logic        bus_err,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata,
  output logic        mem_wdata_oe,
  output logic        mem_ce_n,
  output logic        mem_oe_n,
  output logic        mem_we_n,
  output logic        io_req,
  output logic        io_we,
  output logic [7:0]  io_addr,
  output logic [7:0]  io_wdata,
  input  logic [7:0]  io_rdata,
  input  logic        io_ack
);

  localparam logic [7:0] RD_LAST = 8'(WAIT_RD - 1);
  localparam logic [7:0] WR_LAST = 8'(WAIT_WR - 1);
  localparam logic [7:0] TO_LAST = 8'(IO_TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [15:0] addr_q, addr_d;
  logic        we_q, we_d;
  logic [7:0]  wdata_q, wdata_d;
  logic [7:0]  rdata_q, rdata_d;
  logic        err_q, err_d;
  region_e     region;

  javk_memctl_decode #(
    .ROM_TOP(ROM_TOP),
    .IO_PAGE(IO_PAGE)
  ) u_decode (
    .addr  (cpu_addr),
    .region(region)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    we_d    = we_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (cpu_req) begin
          addr_d  = cpu_addr;
          we_d    = cpu_we;
          wdata_d = cpu_wdata;
          err_d   = 1'b0;
          cnt_d   = 8'd0;
          if (region == REG_IO) begin
            state_d = IO_WAIT;
          end else if (region == REG_ROM && cpu_we) begin
            // ROM writes never touch the bus; they just report an error.
            state_d = DONE;
            err_d   = 1'b1;
          end else begin
            state_d = SETUP;
          end
        end
      end
      SETUP: begin
        state_d = ACCESS;
        cnt_d   = 8'd0;
      end
      ACCESS: begin
        if (cnt_q == (we_q ? WR_LAST : RD_LAST)) begin
          cnt_d = 8'd0;
          if (we_q) begin
            state_d = HOLD;
          end else begin
            state_d = DONE;
            rdata_d = mem_rdata;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      HOLD: state_d = DONE;
      IO_WAIT: begin
        // Ack is checked first so a coincident ack beats the timeout.
        if (io_ack) begin
          if (!we_q) rdata_d = io_rdata;
          state_d = DONE;
        end else if (cnt_q == TO_LAST) begin
          if (!we_q) rdata_d = 8'hFF;
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
      addr_q  <= 16'd0;
      we_q    <= 1'b0;
      wdata_q <= 8'd0;
      rdata_q <= 8'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  logic mem_cycle;
  assign mem_cycle = (state_q == SETUP) || (state_q == ACCESS) || (state_q == HOLD);

  assign cpu_rdata    = rdata_q;
  assign cpu_ready    = (state_q == DONE);
  assign bus_err      = (state_q == DONE) && err_q;
  assign busy         = (state_q != IDLE);
  assign mem_addr     = addr_q;
  assign mem_wdata    = wdata_q;
  assign mem_ce_n     = !mem_cycle;
  // Only reads assert oe_n and only writes assert we_n, so they can never overlap.
  assign mem_oe_n     = !(!we_q && ((state_q == SETUP) || (state_q == ACCESS)));
  assign mem_we_n     = !(we_q && (state_q == ACCESS));
  assign mem_wdata_oe = we_q && mem_cycle;
  assign io_req       = (state_q == IO_WAIT);
  assign io_we        = (state_q == IO_WAIT) && we_q;
  assign io_addr      = addr_q[7:0];
  assign io_wdata     = wdata_q;

endmodule
